fetch_stage: RTL and testbench

- Instruction-fetch stage of the WISC-SP23 pipeline, directly upstream of the decode stage.
- Owns the PC and the instruction-memory request interface.
- Owns the IF/ID pipeline register, which supplies decode with instr[15:0] and incr_PC[15:0].
- Handles hazard stalls, branch/jump redirects (flush), multi-cycle memory, HALT and misaligned-PC errors.

---
 rtl/wisc_pkg.sv | 56 +++++
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_hold_buf.sv | 33 +++
 rtl/fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC-SP23 definitions used by the fetch and decode stages.
package wisc_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] HALT_OP = 5'b00000;
  localparam logic [OP_W-1:0] NOP_OP  = 5'b00001;
  localparam logic [OP_W-1:0] J_OP    = 5'b00100;
  localparam logic [OP_W-1:0] JR_OP   = 5'b00101;
  localparam logic [OP_W-1:0] JAL_OP  = 5'b00110;
  localparam logic [OP_W-1:0] JALR_OP = 5'b00111;
  localparam logic [OP_W-1:0] LBI_OP  = 5'b11000;
  localparam logic [OP_W-1:0] SLBI_OP = 5'b10010;

  localparam logic [XLEN-1:0] NOP_INSTR = {NOP_OP, 11'b0};

  typedef enum logic [1:0] {
    FS_RUN     = 2'd0,
    FS_DISCARD = 2'd1,
    FS_HALT    = 2'd2,
    FS_ERR     = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    TYPE_J  = 2'd0,
    TYPE_I1 = 2'd1,
    TYPE_I2 = 2'd2,
    TYPE_R  = 2'd3
  } instr_type_e;

  // IF/ID payload, also the skid-buffer entry
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] incr_pc;
    logic            valid;
  } ifid_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[XLEN-1 -: OP_W];
  endfunction

  // Instruction format class from the opcode, shared so decode and fetch agree
  function automatic instr_type_e type_of(input logic [OP_W-1:0] op);
    instr_type_e t;
    t = TYPE_I1;
    casez (op)
      J_OP, JAL_OP:                             t = TYPE_J;
      5'b011??, LBI_OP, SLBI_OP, JR_OP, JALR_OP: t = TYPE_I2;
      5'b11001, 5'b1101?, 5'b111??:             t = TYPE_R;
      default:                                  t = TYPE_I1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect control, instruction memory and IF/ID outputs.
interface fetch_stage_if;
  import wisc_pkg::*;

  logic            stall_i;
  logic            flush_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_rd_o;
  logic [XLEN-1:0] imem_addr_o;
  logic [XLEN-1:0] imem_data_i;
  logic            imem_done_i;
  logic [XLEN-1:0] ifid_instr_o;
  logic [XLEN-1:0] ifid_incr_pc_o;
  logic            ifid_valid_o;
  logic            halted_o;
  logic            err_o;

  modport master (
    input  stall_i, flush_i, redirect_pc_i, imem_data_i, imem_done_i,
    output imem_rd_o, imem_addr_o, ifid_instr_o, ifid_incr_pc_o, ifid_valid_o,
           halted_o, err_o
  );

  modport slave (
    output stall_i, flush_i, redirect_pc_i, imem_data_i, imem_done_i,
    input  imem_rd_o, imem_addr_o, ifid_instr_o, ifid_incr_pc_o, ifid_valid_o,
           halted_o, err_o
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer that parks a fetched word while decode is stalled.
module fetch_hold_buf
  import wisc_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  drain,
  input  logic  clear,
  input  ifid_t din,
  output ifid_t dout,
  output logic  full
);

  ifid_t entry_q;

  // clear (flush) beats load; load and drain never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '{instr: NOP_INSTR, incr_pc: '0, valid: 1'b0};
    end else if (clear) begin
      entry_q.valid <= 1'b0;
    end else if (load) begin
      entry_q <= din;
    end else if (drain) begin
      entry_q.valid <= 1'b0;
    end
  end

  assign dout = entry_q;
  assign full = entry_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// WISC-SP23 instruction fetch: PC, imem request, IF/ID register, redirect/halt/error control.
module fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        bus
);

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, incr_pc: '0, valid: 1'b0};

  fetch_state_e    state_q, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [XLEN-1:0] redir_q, redir_n;
  logic [XLEN-1:0] pc_plus2;
  ifid_t           ifid_q, ifid_n;
  ifid_t           hb_din, hb_dout;
  logic            rd_q, rd_n;
  logic            halted_q, halted_n;
  logic            err_q, err_n;
  logic            hb_load, hb_drain, hb_clear, hb_full;
  logic            hold_n;
  logic            take;
  logic            is_halt;

  assign pc_plus2 = pc_q + XLEN'(2);
  assign take     = rd_q && bus.imem_done_i;
  assign is_halt  = (opcode_of(bus.imem_data_i) == HALT_OP);
  assign hb_din   = '{instr: bus.imem_data_i, incr_pc: pc_plus2, valid: 1'b1};

  fetch_hold_buf u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hb_load),
    .drain (hb_drain),
    .clear (hb_clear),
    .din   (hb_din),
    .dout  (hb_dout),
    .full  (hb_full)
  );

  // Next-state, PC and IF/ID selection
  always_comb begin
    state_n  = state_q;
    pc_n     = pc_q;
    redir_n  = redir_q;
    ifid_n   = ifid_q;
    halted_n = halted_q;
    err_n    = err_q;
    hb_load  = 1'b0;
    hb_drain = 1'b0;
    hb_clear = 1'b0;

    unique case (state_q)
      FS_RUN: begin
        if (bus.flush_i) begin
          ifid_n   = BUBBLE;
          hb_clear = 1'b1;
          // an in-flight access must complete before the new PC can be issued
          if (rd_q && !bus.imem_done_i) begin
            redir_n = bus.redirect_pc_i;
            state_n = FS_DISCARD;
          end else begin
            pc_n = bus.redirect_pc_i;
          end
        end else if (pc_q[0]) begin
          state_n  = FS_ERR;
          err_n    = 1'b1;
          ifid_n   = BUBBLE;
          hb_clear = 1'b1;
        end else if (hb_full) begin
          if (!bus.stall_i) begin
            ifid_n   = hb_dout;
            hb_drain = 1'b1;
          end
        end else if (take) begin
          pc_n = pc_plus2;
          if (bus.stall_i) begin
            hb_load = 1'b1;
          end else begin
            ifid_n = hb_din;
          end
          if (is_halt) begin
            state_n  = FS_HALT;
            halted_n = 1'b1;
          end
        end else if (!bus.stall_i) begin
          ifid_n = BUBBLE;
        end
      end

      FS_DISCARD: begin
        ifid_n = BUBBLE;
        if (bus.flush_i) begin
          redir_n = bus.redirect_pc_i;
        end
        if (take) begin
          pc_n    = bus.flush_i ? bus.redirect_pc_i : redir_q;
          state_n = FS_RUN;
        end
      end

      FS_HALT: begin
        // a flush here means the HALT was on a squashed path
        if (bus.flush_i) begin
          pc_n     = bus.redirect_pc_i;
          halted_n = 1'b0;
          state_n  = FS_RUN;
          ifid_n   = BUBBLE;
          hb_clear = 1'b1;
        end else if (!bus.stall_i) begin
          if (hb_full) begin
            ifid_n   = hb_dout;
            hb_drain = 1'b1;
          end else begin
            ifid_n = BUBBLE;
          end
        end
      end

      FS_ERR: begin
        ifid_n = BUBBLE;
      end

      default: begin
        state_n = FS_ERR;
      end
    endcase
  end

  // Request flag is registered from the post-edge view of state, hold and PC
  assign hold_n = hb_clear ? 1'b0 :
                  hb_load  ? 1'b1 :
                  hb_drain ? 1'b0 : hb_full;
  assign rd_n   = ((state_n == FS_RUN) || (state_n == FS_DISCARD)) && !hold_n && !pc_n[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FS_RUN;
      pc_q     <= RESET_PC;
      redir_q  <= '0;
      ifid_q   <= BUBBLE;
      rd_q     <= !RESET_PC[0];
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      redir_q  <= redir_n;
      ifid_q   <= ifid_n;
      rd_q     <= rd_n;
      halted_q <= halted_n;
      err_q    <= err_n;
    end
  end

  assign bus.imem_rd_o      = rd_q;
  assign bus.imem_addr_o    = pc_q;
  assign bus.ifid_instr_o   = ifid_q.instr;
  assign bus.ifid_incr_pc_o = ifid_q.incr_pc;
  assign bus.ifid_valid_o   = ifid_q.valid;
  assign bus.halted_o       = halted_q;
  assign bus.err_o          = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences, random stream check.
module tb_fetch_stage;

  logic clk;
  logic rst_n;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:32767];

  // memory responder state
  int          lat = 0;
  logic        waiting = 1'b0;
  int          wcnt = 0;
  int          wlat = 0;
  logic [15:0] waddr = 16'h0000;

  typedef struct {
    logic        rst;
    int          lat;
    logic        stall;
    logic        flush;
    logic [15:0] tgt;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] incr;
    logic        rd;
    logic [15:0] addr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, int l, logic s, logic f, logic [15:0] t,
                              logic v, logic [15:0] ins, logic [15:0] inc,
                              logic rd, logic [15:0] ad);
    vec_t x;
    x.rst = r; x.lat = l; x.stall = s; x.flush = f; x.tgt = t;
    x.valid = v; x.instr = ins; x.incr = inc; x.rd = rd; x.addr = ad;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Program contents: no HALT opcode anywhere, then directed words on top
  task automatic fill_mem();
    logic [15:0] w;
    for (int i = 0; i < 32768; i++) begin
      w = 16'(i * 40503 + 12345);
      if (w[15:11] == 5'b00000) w[15:11] = 5'b10011;
      mem[i] = w;
    end
  endtask

  task automatic load_directed();
    mem[0]      = 16'hC105;
    mem[1]      = 16'h0800;
    mem[2]      = 16'h2A02;
    mem[3]      = 16'h0000;
    mem[8]      = 16'h5555;
    mem[16'h20] = 16'h4321;
    mem[16'h7FFF] = 16'h6789;
  endtask

  task automatic drive_idle();
    bus.stall_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.redirect_pc_i = 16'h0000;
    bus.imem_done_i   = 1'b0;
    bus.imem_data_i   = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    waiting = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: respond to the pending request, drive controls, sample at the next negedge
  task automatic step(input logic st, input logic fl, input logic [15:0] tg);
    logic        rd;
    logic [15:0] ad;
    logic        dn;
    rd = bus.imem_rd_o;
    ad = bus.imem_addr_o;
    dn = 1'b0;
    if (waiting) chk("req_stable", 64'({rd, ad}), 64'({1'b1, waddr}));
    if (rd) begin
      if (!waiting) begin
        waiting = 1'b1;
        wcnt    = 0;
        wlat    = lat;
        waddr   = ad;
      end
      if (wcnt >= wlat) begin
        dn      = 1'b1;
        waiting = 1'b0;
      end else begin
        wcnt++;
      end
    end
    bus.imem_done_i   = dn;
    bus.imem_data_i   = dn ? mem[ad[15:1]] : 16'hDEAD;
    bus.stall_i       = st;
    bus.flush_i       = fl;
    bus.redirect_pc_i = tg;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_if(input string tag, input logic v, input logic [15:0] ins,
                           input logic [15:0] inc, input logic rd, input logic [15:0] ad);
    chk({tag, "_valid"}, 64'(bus.ifid_valid_o), 64'(v));
    if (v) begin
      chk({tag, "_instr"}, 64'(bus.ifid_instr_o), 64'(ins));
      chk({tag, "_incr"}, 64'(bus.ifid_incr_pc_o), 64'(inc));
    end else begin
      chk({tag, "_bubble"}, 64'(bus.ifid_instr_o), 64'(16'h0800));
    end
    chk({tag, "_rd"}, 64'(bus.imem_rd_o), 64'(rd));
    chk({tag, "_addr"}, 64'(bus.imem_addr_o), 64'(ad));
  endtask

  initial begin
    logic [15:0] exp_addr;
    logic [32:0] prev;
    logic        st, fl;
    logic [15:0] tg;
    int          accepted;

    rst_n = 1'b0;
    drive_idle();
    fill_mem();
    load_directed();

    // zero-wait sequential fetch
    vt.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 16'hC105, 16'h0002, 1, 16'h0002));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h0800, 16'h0004, 1, 16'h0004));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h2A02, 16'h0006, 1, 16'h0006));
    // slow memory, stall across the done cycle
    vt.push_back(mk(1, 2, 0, 0, 16'h0000, 0, 16'h0800, 16'h0000, 1, 16'h0000));
    vt.push_back(mk(0, 2, 1, 0, 16'h0000, 0, 16'h0800, 16'h0000, 1, 16'h0000));
    vt.push_back(mk(0, 2, 1, 0, 16'h0000, 0, 16'h0800, 16'h0000, 0, 16'h0002));
    vt.push_back(mk(0, 2, 1, 0, 16'h0000, 0, 16'h0800, 16'h0000, 0, 16'h0002));
    vt.push_back(mk(0, 2, 0, 0, 16'h0000, 1, 16'hC105, 16'h0002, 1, 16'h0002));
    vt.push_back(mk(0, 2, 0, 0, 16'h0000, 0, 16'h0800, 16'h0000, 1, 16'h0002));
    // flush while the access at 4 is outstanding
    vt.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 16'hC105, 16'h0002, 1, 16'h0002));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h0800, 16'h0004, 1, 16'h0004));
    vt.push_back(mk(0, 3, 0, 1, 16'h0040, 0, 16'h0800, 16'h0000, 1, 16'h0004));
    vt.push_back(mk(0, 3, 0, 0, 16'h0000, 0, 16'h0800, 16'h0000, 1, 16'h0004));
    vt.push_back(mk(0, 3, 1, 0, 16'h0000, 0, 16'h0800, 16'h0000, 1, 16'h0004));
    vt.push_back(mk(0, 3, 0, 0, 16'h0000, 0, 16'h0800, 16'h0000, 1, 16'h0040));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h4321, 16'h0042, 1, 16'h0042));

    do_reset();
    chk("reset_valid", 64'(bus.ifid_valid_o), 64'(0));
    chk("reset_instr", 64'(bus.ifid_instr_o), 64'(16'h0800));
    chk("reset_incr", 64'(bus.ifid_incr_pc_o), 64'(0));
    chk("reset_flags", 64'({bus.halted_o, bus.err_o}), 64'(0));
    chk("reset_addr", 64'(bus.imem_addr_o), 64'(0));

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      lat = vt[i].lat;
      step(vt[i].stall, vt[i].flush, vt[i].tgt);
      expect_if($sformatf("vec%0d", i), vt[i].valid, vt[i].instr, vt[i].incr,
                vt[i].rd, vt[i].addr);
    end

    // HALT at 6, then an older branch squashes it
    do_reset();
    lat = 0;
    repeat (3) step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_if("halt_word", 1'b1, 16'h0000, 16'h0008, 1'b0, 16'h0008);
    chk("halt_set", 64'(bus.halted_o), 64'(1));
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 16'h0000);
      expect_if("halt_idle", 1'b0, 16'h0800, 16'h0000, 1'b0, 16'h0008);
      chk("halt_hold", 64'(bus.halted_o), 64'(1));
    end
    step(1'b0, 1'b1, 16'h0010);
    expect_if("halt_flush", 1'b0, 16'h0800, 16'h0000, 1'b1, 16'h0010);
    chk("halt_clear", 64'(bus.halted_o), 64'(0));
    step(1'b0, 1'b0, 16'h0000);
    expect_if("halt_resume", 1'b1, 16'h5555, 16'h0012, 1'b1, 16'h0012);

    // misaligned redirect
    do_reset();
    lat = 0;
    step(1'b0, 1'b1, 16'h0033);
    expect_if("mis_redir", 1'b0, 16'h0800, 16'h0000, 1'b0, 16'h0033);
    chk("mis_err0", 64'(bus.err_o), 64'(0));
    step(1'b0, 1'b0, 16'h0000);
    chk("mis_err1", 64'(bus.err_o), 64'(1));
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 16'h0010);
      expect_if("mis_stuck", 1'b0, 16'h0800, 16'h0000, 1'b0, 16'h0033);
      chk("mis_sticky", 64'(bus.err_o), 64'(1));
    end
    do_reset();
    chk("mis_reset_err", 64'(bus.err_o), 64'(0));
    chk("mis_reset_rd", 64'({bus.imem_rd_o, bus.imem_addr_o}), 64'({1'b1, 16'h0000}));

    // PC wrap and asynchronous reset mid-access
    do_reset();
    lat = 0;
    step(1'b0, 1'b1, 16'hFFFE);
    expect_if("wrap_redir", 1'b0, 16'h0800, 16'h0000, 1'b1, 16'hFFFE);
    step(1'b0, 1'b0, 16'h0000);
    expect_if("wrap_fetch", 1'b1, 16'h6789, 16'h0000, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    expect_if("wrap_next", 1'b1, 16'hC105, 16'h0002, 1'b1, 16'h0002);
    lat = 3;
    step(1'b1, 1'b0, 16'h0000);
    expect_if("async_pre", 1'b1, 16'hC105, 16'h0002, 1'b1, 16'h0002);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(bus.ifid_valid_o), 64'(0));
    chk("async_instr", 64'(bus.ifid_instr_o), 64'(16'h0800));
    chk("async_incr", 64'(bus.ifid_incr_pc_o), 64'(0));
    chk("async_addr", 64'(bus.imem_addr_o), 64'(0));
    chk("async_flags", 64'({bus.halted_o, bus.err_o}), 64'(0));

    // Random: IF/ID must deliver the program-order word stream from the latest redirect target
    fill_mem();
    do_reset();
    exp_addr = 16'h0000;
    accepted = 0;
    for (int n = 0; n < 800; n++) begin
      st   = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      tg   = 16'($urandom_range(0, 511)) & 16'hFFFE;
      lat  = int'($urandom_range(0, 3));
      prev = {bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_incr_pc_o};
      step(st, fl, tg);
      chk("rnd_flags", 64'({bus.halted_o, bus.err_o}), 64'(0));
      if (fl) begin
        chk("rnd_flush_bubble", 64'(bus.ifid_valid_o), 64'(0));
        exp_addr = tg;
      end else if (st) begin
        chk("rnd_stall_hold", 64'({bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_incr_pc_o}),
            64'(prev));
      end else if (bus.ifid_valid_o) begin
        chk("rnd_instr", 64'(bus.ifid_instr_o), 64'(mem[exp_addr[15:1]]));
        chk("rnd_incr", 64'(bus.ifid_incr_pc_o), 64'(exp_addr + 16'd2));
        exp_addr = exp_addr + 16'd2;
        accepted++;
      end
    end
    chk("rnd_progress", 64'(accepted >= 50), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
